sink_checker: RTL

SINK_CHECKER -- requirements
Module: sink_checker

---
 rtl/sink_checker.sv | 99 +++++++++
 1 files changed

// File: rtl/sink_checker.sv
// sink_checker: receives a DEPTH-word stream, checks it against an
// incrementing reference (1, 2, 3, ... wrapping at 2^WIDTH), captures every
// accepted word in a readback memory and reports error statistics.
module sink_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int BP_EN = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      rx_cnt,
    output logic [15:0]      err_cnt,
    output logic [AW:0]      first_err_idx,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] NO_ERR   = '1;

    state_t           state, state_nxt;
    logic [7:0]       lfsr;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             hs;

    assign hs = valid && ready;

    // State register
    always_ff @(posedge clk) begin
        if (s_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: start only matters in IDLE; DONE is sticky until reset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV:    if (hs && rx_cnt == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend on registered state only, never on valid
    always_comb begin
        ready = (state == RECV) && (BP_EN == 0 || lfsr[0]);
        done  = (state == DONE);
        pass  = done && (err_cnt == 16'd0);
    end

    // Backpressure LFSR (taps 8,6,5,4); frozen outside RECV so each run
    // sees the same ready pattern
    always_ff @(posedge clk) begin
        if (s_rst)
            lfsr <= 8'hA5;
        else if (state == RECV)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Counters and reference value, updated on each accepted word
    always_ff @(posedge clk) begin
        if (s_rst) begin
            rx_cnt        <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
            expected      <= WIDTH'(1);
        end else if (hs) begin
            rx_cnt   <= rx_cnt + 1'b1;
            expected <= expected + 1'b1;
            if (data_in != expected) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (first_err_idx == NO_ERR) first_err_idx <= rx_cnt;
            end
        end
    end

    // Capture memory: not cleared by reset, written on handshake
    always_ff @(posedge clk) begin
        if (hs) mem[rx_cnt[AW-1:0]] <= data_in;
    end

    // Registered readback; a same-cycle write returns the old word
    always_ff @(posedge clk) begin
        if (s_rst) rb_data <= '0;
        else       rb_data <= mem[rb_addr];
    end

endmodule
